// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the IF-stage next-PC sequencer: default widths and FSM encoding.
package pipeline_pkg;

    localparam int unsigned PC_ADDR_W      = 8;
    localparam int unsigned PC_INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SHADOW = 3'd2,
        ST_STALL  = 3'd3,
        ST_HALT   = 3'd4
    } pc_state_e;

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check and sanitisation of a redirect target.
// PC_SEQ_ALIGN_CHECK_EN: misaligned targets are illegal instead of being silently aligned.
module pc_target_check #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MAX_ADDR = 124
) (
    input  logic [ADDR_W-1:0] target,
    output logic              legal_c,
    output logic [ADDR_W-1:0] target_san_c
);

    // The PC is signed: a set MSB is a negative, never-fetchable address.
`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign target_san_c = target;
    assign legal_c      = !target[ADDR_W-1]
                       && (target <= ADDR_W'(MAX_ADDR))
                       && (target[1:0] == 2'b00);
`else
    assign target_san_c = target & ~ADDR_W'(3);
    assign legal_c      = !target_san_c[ADDR_W-1]
                       && (target_san_c <= ADDR_W'(MAX_ADDR));
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the IF stage: sequential fetch, branch/jump redirect, stall, halt and fault trap.
// Alignment trapping of redirect targets is enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W        = PC_ADDR_W,
    parameter int unsigned INSTR_BYTES   = PC_INSTR_BYTES,
    parameter int unsigned RESET_VECTOR  = 0,
    parameter int unsigned MAX_ADDR      = 124,
    parameter int unsigned SHADOW_CYCLES = 1,
    parameter int unsigned STALL_MAX     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] curr_addr,
    input  logic              stall_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] next_addr,
    output logic              pc_write,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              halted,
    output logic              fault
);

    localparam int unsigned SUM_W    = ADDR_W + 1;
    localparam int unsigned STALL_W  = $clog2(STALL_MAX + 1);
    localparam int unsigned STALL_CW = STALL_W + 1;
    localparam int unsigned SHADOW_W = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES + 1) : 1;

    pc_state_e           state_q, state_d;
    logic                fault_q, fault_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [SHADOW_W-1:0] shadow_cnt_q, shadow_cnt_d;

    logic                br_legal, jmp_legal;
    logic [ADDR_W-1:0]   br_target_san, jmp_target_san;
    logic [SUM_W-1:0]    seq_sum;
    logic                seq_ok;
    logic [STALL_CW-1:0] stall_inc;
    logic                take_seq;

    pc_target_check #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) u_br_check (
        .target       (branch_target),
        .legal_c      (br_legal),
        .target_san_c (br_target_san)
    );

    pc_target_check #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) u_jmp_check (
        .target       (jump_target),
        .legal_c      (jmp_legal),
        .target_san_c (jmp_target_san)
    );

    // One extra bit so a fetch past the top of memory is seen rather than wrapped.
    assign seq_sum   = {1'b0, curr_addr} + SUM_W'(INSTR_BYTES);
    assign seq_ok    = (seq_sum <= SUM_W'(MAX_ADDR));
    assign stall_inc = {1'b0, stall_cnt_q} + STALL_CW'(1);

    assign halted = (state_q == ST_HALT);
    assign fault  = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            fault_q      <= 1'b0;
            stall_cnt_q  <= '0;
            shadow_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            stall_cnt_q  <= stall_cnt_d;
            shadow_cnt_q <= shadow_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        stall_cnt_d  = stall_cnt_q;
        shadow_cnt_d = shadow_cnt_q;
        next_addr    = curr_addr;
        pc_write     = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        take_seq     = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                next_addr   = ADDR_W'(RESET_VECTOR);
                pc_write    = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (branch_taken) begin
                    stall_cnt_d = '0;
                    if (br_legal) begin
                        next_addr    = br_target_san;
                        pc_write     = 1'b1;
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        shadow_cnt_d = SHADOW_W'(SHADOW_CYCLES);
                        state_d      = ST_SHADOW;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (jump_req) begin
                    stall_cnt_d = '0;
                    if (jmp_legal) begin
                        next_addr   = jmp_target_san;
                        pc_write    = 1'b1;
                        flush_if_id = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (halt_req) begin
                    stall_cnt_d = '0;
                    flush_if_id = 1'b1;
                    state_d     = ST_HALT;
                end else if (stall_req) begin
                    // A hazard that never clears is treated as a hung pipeline.
                    if (stall_inc >= STALL_CW'(STALL_MAX)) begin
                        stall_cnt_d = '0;
                        fault_d     = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        stall_cnt_d = stall_inc[STALL_W-1:0];
                        state_d     = ST_STALL;
                    end
                end else begin
                    take_seq = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_SHADOW: begin
                take_seq = 1'b1;
                if (shadow_cnt_q <= SHADOW_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    shadow_cnt_d = shadow_cnt_q - SHADOW_W'(1);
                end
            end
            ST_HALT: begin
                if (resume && !fault_q) begin
                    take_seq = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Shared sequential fetch; running off the end of memory overrides the chosen state.
        if (take_seq) begin
            stall_cnt_d = '0;
            if (seq_ok) begin
                next_addr = seq_sum[ADDR_W-1:0];
                pc_write  = 1'b1;
            end else begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer using the default parameter set.
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] curr_addr;
    logic       stall_req;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       jump_req;
    logic [7:0] jump_target;
    logic       halt_req;
    logic       resume;
    logic [7:0] next_addr;
    logic       pc_write;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       halted;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .curr_addr     (curr_addr),
        .stall_req     (stall_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_req      (jump_req),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .next_addr     (next_addr),
        .pc_write      (pc_write),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        stall_req     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'd0;
        jump_req      = 1'b0;
        jump_target   = 8'd0;
        halt_req      = 1'b0;
        resume        = 1'b0;
    endtask

    // Apply reset, release it, and check the single BOOT cycle.
    task automatic do_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        curr_addr = 8'd0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_pcw"},   32'(pc_write), 32'd1);
        chk({tag, "_rst_fault"}, 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_boot_next"},  32'(next_addr), 32'd0);
        chk({tag, "_boot_flush"}, {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        chk({tag, "_boot_halt"},  32'(halted), 32'd0);
    endtask

    task automatic step(input logic [7:0] pc);
        @(negedge clk);
        idle_inputs();
        curr_addr = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        curr_addr = 8'd0;
        idle_inputs();

        do_reset("r1");
        for (int i = 0; i < 3; i++) begin
            step(8'(4 * i));
            #1;
            chk("seq_next",  32'(next_addr), 32'(4 * (i + 1)));
            chk("seq_pcw",   32'(pc_write), 32'd1);
            chk("seq_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        end

        // Branch beats a simultaneous jump; jump in the shadow cycle is ignored.
        step(8'd20);
        branch_taken = 1'b1; branch_target = 8'd64;
        jump_req = 1'b1; jump_target = 8'd40;
        #1;
        chk("br_next",  32'(next_addr), 32'd64);
        chk("br_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        step(8'd64);
        jump_req = 1'b1; jump_target = 8'd40;
        #1;
        chk("shadow_next",  32'(next_addr), 32'd68);
        chk("shadow_flush", 32'(flush_if_id), 32'd0);
        step(8'd68);
        #1;
        chk("post_shadow_next", 32'(next_addr), 32'd72);

        // Short stall then release.
        for (int i = 0; i < 3; i++) begin
            step(8'd16);
            stall_req = 1'b1;
            #1;
            chk("stall3_pcw",   32'(pc_write), 32'd0);
            chk("stall3_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        end
        step(8'd16);
        #1;
        chk("stall_rel_next", 32'(next_addr), 32'd20);
        chk("stall_rel_pcw",  32'(pc_write), 32'd1);

        // Stall held to the limit traps.
        for (int i = 0; i < 15; i++) begin
            step(8'd16);
            stall_req = 1'b1;
            #1;
            chk("stall15_pcw",  32'(pc_write), 32'd0);
            chk("stall15_halt", 32'(halted), 32'd0);
        end
        step(8'd16);
        resume = 1'b1;
        #1;
        chk("stall_fault",  32'(fault), 32'd1);
        chk("stall_halted", 32'(halted), 32'd1);
        chk("stall_res_pcw", 32'(pc_write), 32'd0);
        step(8'd16);
        #1;
        chk("stall_res_halt", 32'(halted), 32'd1);

        // Sequential overflow at the top of memory.
        do_reset("r2");
        step(8'd124);
        #1;
        chk("ovf_pcw", 32'(pc_write), 32'd0);
        step(8'd124);
        resume = 1'b1;
        #1;
        chk("ovf_fault",   32'(fault), 32'd1);
        chk("ovf_halted",  32'(halted), 32'd1);
        chk("ovf_res_pcw", 32'(pc_write), 32'd0);

        // Halt and resume.
        do_reset("r3");
        step(8'd32);
        halt_req = 1'b1;
        #1;
        chk("halt_pcw",   32'(pc_write), 32'd0);
        chk("halt_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);
        step(8'd32);
        #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_hold_pcw", 32'(pc_write), 32'd0);
        step(8'd32);
        resume = 1'b1;
        #1;
        chk("resume_next", 32'(next_addr), 32'd36);
        chk("resume_pcw",  32'(pc_write), 32'd1);
        step(8'd36);
        #1;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_fault",  32'(fault), 32'd0);

        // Misaligned jump target.
        do_reset("r4");
        step(8'd8);
        jump_req = 1'b1; jump_target = 8'd42;
        #1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        chk("jmp42_pcw", 32'(pc_write), 32'd0);
        step(8'd8);
        #1;
        chk("jmp42_fault", 32'(fault), 32'd1);
        chk("jmp42_halt",  32'(halted), 32'd1);
`else
        chk("jmp42_next",  32'(next_addr), 32'd40);
        chk("jmp42_pcw",   32'(pc_write), 32'd1);
        chk("jmp42_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);
        step(8'd40);
        #1;
        chk("jmp42_fault", 32'(fault), 32'd0);
`endif

        // Negative jump target always traps.
        do_reset("r5");
        step(8'd8);
        jump_req = 1'b1; jump_target = 8'h90;
        #1;
        chk("jmp90_pcw",   32'(pc_write), 32'd0);
        chk("jmp90_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        step(8'd8);
        #1;
        chk("jmp90_fault", 32'(fault), 32'd1);
        chk("jmp90_halt",  32'(halted), 32'd1);

        // Branch with simultaneous stall clears the stall count.
        do_reset("r6");
        for (int i = 0; i < 10; i++) begin
            step(8'd0);
            stall_req = 1'b1;
        end
        step(8'd0);
        stall_req = 1'b1; branch_taken = 1'b1; branch_target = 8'd64;
        #1;
        chk("brst_next", 32'(next_addr), 32'd64);
        chk("brst_pcw",  32'(pc_write), 32'd1);
        step(8'd64);
        stall_req = 1'b1;
        #1;
        chk("brst_shadow_next", 32'(next_addr), 32'd68);
        for (int i = 0; i < 14; i++) begin
            step(8'd68);
            stall_req = 1'b1;
            #1;
            chk("brst_stall_halt", 32'(halted), 32'd0);
        end
        step(8'd68);
        #1;
        chk("brst_rel_next",  32'(next_addr), 32'd72);
        chk("brst_rel_fault", 32'(fault), 32'd0);

        // Negative branch target traps.
        step(8'd72);
        branch_taken = 1'b1; branch_target = 8'h90;
        #1;
        chk("br90_pcw", 32'(pc_write), 32'd0);
        step(8'd72);
        #1;
        chk("br90_fault", 32'(fault), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
